program_memory_loader: RTL

Sequencer that owns the PicoBlaze program memory port and reloads it at run time. In normal operation it passes the CPU fetch address straight to the synchronous-read instruction memory. On a load request it holds the CPU in reset, streams instruction words from a host link into consecutive memory addresses, and then releases the CPU so it restarts at address 0. It sits between the PicoBlaze core, the program memory and the host/debug interface of the GPU.

---
 rtl/program_memory_pkg.sv | 17 +
 rtl/program_memory_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/program_memory_pkg.sv
// program_memory_pkg
// Shared definitions for the PicoBlaze program memory loader:
//   - loader_state_t : sequencer states (IDLE, LOAD, RELEASE)
//   - DEFAULT_*      : default memory geometry and CPU release delay
package program_memory_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 10;
  localparam int DEFAULT_DATA_WIDTH     = 18;
  localparam int DEFAULT_RELEASE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RELEASE = 2'd2
  } loader_state_t;

endpackage

// File: rtl/program_memory_loader.sv
// program_memory_loader
// Owns the PicoBlaze program memory port. In IDLE the CPU fetch address is
// passed straight to the synchronous-read instruction memory. A load request
// holds the CPU in reset, streams host words into consecutive addresses from
// 0, then keeps the CPU in reset for RELEASE_CYCLES more cycles so it restarts
// cleanly at address 0.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   load_start/length     load request (sampled in IDLE), word count 1..2^AW
//   load_abort            ends a load early (sampled in LOAD)
//   s_valid/s_data/s_ready host word stream (valid/ready handshake)
//   cpu_address           PicoBlaze fetch address
//   cpu_instruction       instruction to the CPU (= mem_read_data)
//   cpu_reset             active-high reset to the PicoBlaze
//   mem_address, mem_write_enable, mem_write_data, mem_read_data
//                         external program memory port
//   busy                  high in LOAD and RELEASE
//   done                  pulse when a complete load has been released
//   error                 pulse after a load request with an illegal length
//   checksum              XOR of the words written by the current/last load
module program_memory_loader
  import program_memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int RELEASE_CYCLES = DEFAULT_RELEASE_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_length,
  input  logic                  load_abort,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  output logic [DATA_WIDTH-1:0] cpu_instruction,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_write_enable,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] checksum
);

  localparam int COUNT_WIDTH = (RELEASE_CYCLES < 1) ? 1 : $clog2(RELEASE_CYCLES + 1);
  localparam logic [COUNT_WIDTH-1:0] RELEASE_INIT = COUNT_WIDTH'(RELEASE_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE    = COUNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]    WORD_ONE     = (ADDR_WIDTH + 1)'(1);
  // Largest legal length: a full memory, 2^ADDR_WIDTH words.
  localparam logic [ADDR_WIDTH:0]    MAX_LENGTH   = {1'b1, {ADDR_WIDTH{1'b0}}};

  loader_state_t          state;
  logic [ADDR_WIDTH:0]    word_count;
  logic [ADDR_WIDTH:0]    last_index;
  logic [COUNT_WIDTH-1:0] release_count;
  // Set only when a load finishes with its last word (no abort). Gating done
  // on this flag, rather than on the absence of an abort, keeps the boot
  // release that follows reset from producing a done pulse.
  logic                   load_complete;
  logic                   handshake;
  logic                   length_legal;

  // s_ready is a registered copy of (state == LOAD), so it also selects the
  // loader's address. The write is combinational on the handshake so a word
  // lands in memory on the same edge that accepts it: zero bubbles.
  assign handshake        = s_ready & s_valid;
  assign mem_write_enable = handshake;
  assign mem_write_data   = s_data;
  assign mem_address      = s_ready ? word_count[ADDR_WIDTH-1:0] : cpu_address;
  assign cpu_instruction  = mem_read_data;
  assign length_legal     = (load_length != '0) && (load_length <= MAX_LENGTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // Reset enters RELEASE so the CPU boots through the normal release path.
      state         <= RELEASE;
      release_count <= RELEASE_INIT;
      cpu_reset     <= 1'b1;
      busy          <= 1'b1;
      s_ready       <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      checksum      <= '0;
      word_count    <= '0;
      last_index    <= '0;
      load_complete <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            if (length_legal) begin
              state      <= LOAD;
              word_count <= '0;
              checksum   <= '0;
              last_index <= load_length - WORD_ONE;
              cpu_reset  <= 1'b1;
              busy       <= 1'b1;
              s_ready    <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (handshake) begin
            checksum   <= checksum ^ s_data;
            word_count <= word_count + WORD_ONE;
          end
          // An abort still lets a same-cycle handshake write; it only
          // suppresses the done pulse.
          if (load_abort || (handshake && (word_count == last_index))) begin
            state         <= RELEASE;
            s_ready       <= 1'b0;
            release_count <= RELEASE_INIT;
            load_complete <= ~load_abort;
          end
        end

        RELEASE: begin
          if (release_count <= COUNT_ONE) begin
            state         <= IDLE;
            cpu_reset     <= 1'b0;
            busy          <= 1'b0;
            done          <= load_complete;
            load_complete <= 1'b0;
          end else begin
            release_count <= release_count - COUNT_ONE;
          end
        end

        default: begin
          // Unreachable encoding: recover through a clean CPU release.
          state         <= RELEASE;
          release_count <= RELEASE_INIT;
          cpu_reset     <= 1'b1;
          busy          <= 1'b1;
          s_ready       <= 1'b0;
          load_complete <= 1'b0;
        end
      endcase
    end
  end

endmodule
